dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): VERDICT_DLY, 2, cycles from result_valid to verdict sampling; LFSR_SEED, 16'hACE1, LFSR reset value (non-zero).
REQ-002 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, sole clock, all logic on rising edge.
REQ-003 rst, in, 1, synchronous active-high reset.
REQ-004 roll, in, 1, single-cycle pre-debounced roll request.
REQ-005 new_game, in, 1, single-cycle request to start a new game.
REQ-006 win, in, 1, verdict from turn controller.
REQ-007 lose, in, 1, verdict from turn controller.
REQ-008 num1, out, 4, die 1 value, 0 when no roll has been made, else 1..6.
REQ-009 num2, out, 4, die 2 value, 0 when no roll has been made, else 1..6.
REQ-010 turn, out, 2, 00 no roll, 01 first roll, 10 later roll, 11 game over.
REQ-011 result_valid, out, 1, one-cycle pulse when num1, num2 and turn are updated.
REQ-012 busy, out, 1, high from roll acceptance until verdict sampled.
REQ-013 outcome, out, 2, 00 none, 01 win, 10 lose.
REQ-014 clear_o, out, 1, one-cycle reset pulse to the turn controller.
REQ-015 roll_cnt, out, 4, rolls this game, saturating at 15.

Function
REQ-016 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle except while rst is high, so the user's timing supplies entropy.
REQ-017 The block SHALL implement states IDLE, WAIT, READY and OVER.
REQ-018 In IDLE or READY, a roll seen at edge N SHALL at edge N+1 load num1 = (lfsr[3:0] mod 6)+1 and num2 = (lfsr[7:4] mod 6)+1, using the lfsr value at edge N.
REQ-019 At edge N+1, result_valid SHALL pulse, busy SHALL rise and the state SHALL become WAIT.
REQ-020 turn SHALL become 01 on the first roll of a game and 10 on every later roll; the modulo bias is accepted.
REQ-021 In WAIT, the block SHALL count VERDICT_DLY cycles after result_valid and then sample win/lose once.
REQ-022 If lose is high at the sample, outcome SHALL be 10; else if win is high, outcome SHALL be 01. Lose takes priority when both are high.
REQ-023 If either verdict is set, the state SHALL become OVER and turn SHALL become 11; otherwise the state SHALL become READY. busy SHALL fall on the same edge.
REQ-024 roll SHALL be ignored in WAIT and OVER, with no queuing.
REQ-025 roll_cnt SHALL increment on each accepted roll and hold at 15.
REQ-026 new_game in any state SHALL, on the next edge, return to IDLE and clear num1, num2, turn, outcome, roll_cnt and busy.
REQ-027 new_game SHALL pulse clear_o for exactly one cycle, and SHALL NOT reset the LFSR.
REQ-028 When new_game and roll occur in the same cycle, new_game SHALL win and the roll SHALL be dropped.
REQ-029 num1, num2 and turn SHALL hold stable between result_valid pulses.

Reset
REQ-030 While rst is high, the block SHALL force: state IDLE, num1=0, num2=0, turn=00, result_valid=0, busy=0, outcome=00, clear_o=0, roll_cnt=0, lfsr=LFSR_SEED.
REQ-031 rst SHALL abort any operation, including mid-WAIT, and SHALL take priority over roll and new_game.

Structure
REQ-032 Package dice_pkg SHALL hold the state enum, the turn encodings (TURN_NONE, TURN_FIRST, TURN_LATER, TURN_OVER), the outcome encodings and the default LFSR seed.
REQ-033 The LFSR SHALL be sub-module dice_lfsr (ports clk, rst, seed, q[15:0]); the mod-6 mapping SHALL stay in dice_roller.

Verification
REQ-034 Reset, then pulse roll -> one cycle later num1 and num2 are in 1..6, turn=01, result_valid pulses once, busy=1.
REQ-035 Drive win=1 two cycles after result_valid -> outcome=01, turn=11, busy=0; a further roll produces no change.
REQ-036 Drive win=1 and lose=1 at the sample -> outcome=10, state OVER.
REQ-037 Leave the verdict low, then roll twice more -> turn=10, roll_cnt=3; a roll during WAIT is ignored.
REQ-038 Pulse roll and new_game in the same cycle while in READY -> IDLE, all outputs zero, clear_o pulses once, no result_valid.
REQ-039 Run 6000 rolls with a 0/1 responder -> every num1 and num2 is in 1..6, each face appears, and no value 0 or 7 occurs after the first roll.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared encodings for the dice roller: FSM states, turn/outcome codes and the
// default LFSR seed.
package dice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] TURN_NONE  = 2'b00;
  localparam logic [1:0] TURN_FIRST = 2'b01;
  localparam logic [1:0] TURN_LATER = 2'b10;
  localparam logic [1:0] TURN_OVER  = 2'b11;

  localparam logic [1:0] OUTCOME_NONE = 2'b00;
  localparam logic [1:0] OUTCOME_WIN  = 2'b01;
  localparam logic [1:0] OUTCOME_LOSE = 2'b10;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; reloads seed during rst.
module dice_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic        fb;

  always_comb begin
    fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    q_d = {q_q[14:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dice_roller.sv
// Two-dice roller: snapshots the LFSR on a roll, publishes both faces a cycle
// later, then samples the turn controller's win/lose verdict after a fixed delay.
module dice_roller
  import dice_pkg::*;
#(
  parameter int          VERDICT_DLY = 2,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll,
  input  logic       new_game,
  input  logic       win,
  input  logic       lose,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [1:0] turn,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] outcome,
  output logic       clear_o,
  output logic [3:0] roll_cnt
);

  localparam logic [7:0] DLY_LAST = 8'(VERDICT_DLY - 1);

  // Maps a nibble onto a die face 1..6 (mod-6 bias is accepted).
  function automatic logic [3:0] face(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd12) begin
      r = n - 4'd12;
    end else if (n >= 4'd6) begin
      r = n - 4'd6;
    end else begin
      r = n;
    end
    return r + 4'd1;
  endfunction

  logic [15:0] lfsr_q;
  logic        lfsr_hi_unused;

  dice_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign lfsr_hi_unused = ^lfsr_q[15:8];

  state_e     state_q,        state_d;
  logic [3:0] num1_q,         num1_d;
  logic [3:0] num2_q,         num2_d;
  logic [1:0] turn_q,         turn_d;
  logic       result_valid_q, result_valid_d;
  logic       busy_q,         busy_d;
  logic [1:0] outcome_q,      outcome_d;
  logic       clear_o_q,      clear_o_d;
  logic [3:0] roll_cnt_q,     roll_cnt_d;
  logic       roll_pend_q,    roll_pend_d;
  logic [7:0] lfsr_snap_q,    lfsr_snap_d;
  logic [7:0] wait_cnt_q,     wait_cnt_d;

  always_comb begin
    state_d        = state_q;
    num1_d         = num1_q;
    num2_d         = num2_q;
    turn_d         = turn_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;
    outcome_d      = outcome_q;
    clear_o_d      = 1'b0;
    roll_cnt_d     = roll_cnt_q;
    roll_pend_d    = 1'b0;
    lfsr_snap_d    = lfsr_snap_q;
    wait_cnt_d     = wait_cnt_q;

    if (new_game) begin
      // A new game drops any pending roll; the LFSR keeps running.
      state_d    = ST_IDLE;
      num1_d     = 4'd0;
      num2_d     = 4'd0;
      turn_d     = TURN_NONE;
      busy_d     = 1'b0;
      outcome_d  = OUTCOME_NONE;
      clear_o_d  = 1'b1;
      roll_cnt_d = 4'd0;
      wait_cnt_d = 8'd0;
    end else if (roll_pend_q) begin
      num1_d         = face(lfsr_snap_q[3:0]);
      num2_d         = face(lfsr_snap_q[7:4]);
      turn_d         = (roll_cnt_q == 4'd0) ? TURN_FIRST : TURN_LATER;
      roll_cnt_d     = (roll_cnt_q == 4'hF) ? 4'hF : roll_cnt_q + 4'd1;
      result_valid_d = 1'b1;
      busy_d         = 1'b1;
      wait_cnt_d     = 8'd0;
      state_d        = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_READY: begin
          if (roll) begin
            roll_pend_d = 1'b1;
            lfsr_snap_d = lfsr_q[7:0];
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == DLY_LAST) begin
            busy_d = 1'b0;
            if (lose) begin
              outcome_d = OUTCOME_LOSE;
              turn_d    = TURN_OVER;
              state_d   = ST_OVER;
            end else if (win) begin
              outcome_d = OUTCOME_WIN;
              turn_d    = TURN_OVER;
              state_d   = ST_OVER;
            end else begin
              state_d = ST_READY;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      num1_q         <= 4'd0;
      num2_q         <= 4'd0;
      turn_q         <= TURN_NONE;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      outcome_q      <= OUTCOME_NONE;
      clear_o_q      <= 1'b0;
      roll_cnt_q     <= 4'd0;
      roll_pend_q    <= 1'b0;
      lfsr_snap_q    <= 8'd0;
      wait_cnt_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      turn_q         <= turn_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      outcome_q      <= outcome_d;
      clear_o_q      <= clear_o_d;
      roll_cnt_q     <= roll_cnt_d;
      roll_pend_q    <= roll_pend_d;
      lfsr_snap_q    <= lfsr_snap_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign num1         = num1_q;
  assign num2         = num2_q;
  assign turn         = turn_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign outcome      = outcome_q;
  assign clear_o      = clear_o_q;
  assign roll_cnt     = roll_cnt_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller plus a long roll run with a simple responder.
module tb_dice_roller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       roll = 1'b0;
  logic       new_game = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [1:0] turn;
  logic       result_valid;
  logic       busy;
  logic [1:0] outcome;
  logic       clear_o;
  logic [3:0] roll_cnt;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int clr_cnt = 0;

  dice_roller #(.VERDICT_DLY(2), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst          (rst),
    .roll         (roll),
    .new_game     (new_game),
    .win          (win),
    .lose         (lose),
    .num1         (num1),
    .num2         (num2),
    .turn         (turn),
    .result_valid (result_valid),
    .busy         (busy),
    .outcome      (outcome),
    .clear_o      (clear_o),
    .roll_cnt     (roll_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (clear_o) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Roll, land on the result cycle, then present the verdict for the sample edge.
  task automatic do_roll(input logic w, input logic l, output logic rv, output logic [3:0] n1,
                         output logic [3:0] n2);
    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    rv = result_valid;
    n1 = num1;
    n2 = num2;
    tick();
    win  = w;
    lose = l;
    tick();
    win  = 1'b0;
    lose = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  logic       rv;
  logic [3:0] n1, n2;
  int         rv_before;
  int         bad_range;
  int         bad_rv;
  int         seen1 [1:6];
  int         seen2 [1:6];

  initial begin
    repeat (3) tick();
    check("rst_num1", num1, 0);
    check("rst_num2", num2, 0);
    check("rst_turn", turn, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outcome", outcome, 0);
    check("rst_clear", clear_o, 0);
    check("rst_roll_cnt", roll_cnt, 0);

    // First roll samples the seed 0xACE1: faces (1%6)+1=2 and (14%6)+1=3.
    rst  = 1'b0;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    check("pend_rv", result_valid, 0);
    tick();
    check("r1_num1", num1, 2);
    check("r1_num2", num2, 3);
    check("r1_turn", turn, 2'b01);
    check("r1_rv", result_valid, 1);
    check("r1_busy", busy, 1);
    check("r1_cnt", roll_cnt, 1);
    tick();
    check("r1_rv_once", result_valid, 0);
    check("wait_busy", busy, 1);
    win  = 1'b1;
    roll = 1'b1;
    tick();
    win  = 1'b0;
    roll = 1'b0;
    check("win_outcome", outcome, 2'b01);
    check("win_turn", turn, 2'b11);
    check("win_busy", busy, 0);

    rv_before = rv_cnt;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    repeat (4) tick();
    check("over_no_rv", rv_cnt - rv_before, 0);
    check("over_num1", num1, 2);
    check("over_turn", turn, 2'b11);
    check("over_cnt", roll_cnt, 1);
    check("over_outcome", outcome, 2'b01);

    pulse_new_game();
    check("ng_clear", clear_o, 1);
    check("ng_num1", num1, 0);
    check("ng_num2", num2, 0);
    check("ng_turn", turn, 0);
    check("ng_outcome", outcome, 0);
    check("ng_cnt", roll_cnt, 0);
    check("ng_busy", busy, 0);
    tick();
    check("ng_clear_once", clear_o, 0);

    do_roll(1'b1, 1'b1, rv, n1, n2);
    check("both_rv", rv, 1);
    check("both_outcome", outcome, 2'b10);
    check("both_turn", turn, 2'b11);
    check("both_busy", busy, 0);

    pulse_new_game();
    do_roll(1'b0, 1'b0, rv, n1, n2);
    check("ready_turn", turn, 2'b01);
    check("ready_outcome", outcome, 0);
    check("ready_busy", busy, 0);

    // A roll that lands on the sample edge is seen while still in WAIT.
    rv_before = rv_cnt;
    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    tick();
    roll = 1'b1;
    tick();
    roll = 1'b0;
    repeat (3) tick();
    check("wait_roll_ignored", rv_cnt - rv_before, 1);
    check("wait_roll_cnt", roll_cnt, 2);
    do_roll(1'b0, 1'b0, rv, n1, n2);
    check("later_turn", turn, 2'b10);
    check("later_cnt", roll_cnt, 3);
    check("later_num1", num1, n1);

    rv_before = rv_cnt;
    clr_cnt   = 0;
    roll     = 1'b1;
    new_game = 1'b1;
    tick();
    roll     = 1'b0;
    new_game = 1'b0;
    repeat (3) tick();
    check("ngr_clear_once", clr_cnt, 1);
    check("ngr_no_rv", rv_cnt - rv_before, 0);
    check("ngr_num1", num1, 0);
    check("ngr_num2", num2, 0);
    check("ngr_turn", turn, 0);
    check("ngr_cnt", roll_cnt, 0);
    check("ngr_busy", busy, 0);

    for (int i = 0; i < 17; i++) do_roll(1'b0, 1'b0, rv, n1, n2);
    check("sat_cnt", roll_cnt, 15);
    check("sat_turn", turn, 2'b10);

    pulse_new_game();
    bad_range = 0;
    bad_rv    = 0;
    for (int f = 1; f <= 6; f++) begin
      seen1[f] = 0;
      seen2[f] = 0;
    end
    for (int i = 0; i < 6000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_roll(((i % 5) == 4) ? 1'b1 : 1'b0, 1'b0, rv, n1, n2);
      if (!rv) bad_rv++;
      if (n1 < 1 || n1 > 6 || n2 < 1 || n2 > 6) begin
        bad_range++;
      end else begin
        seen1[n1]++;
        seen2[n2]++;
      end
      if (turn == 2'b11) pulse_new_game();
    end
    check("bulk_range", bad_range, 0);
    check("bulk_rv", bad_rv, 0);
    for (int f = 1; f <= 6; f++) begin
      check($sformatf("face1_%0d_seen", f), (seen1[f] > 0) ? 1 : 0, 1);
      check($sformatf("face2_%0d_seen", f), (seen2[f] > 0) ? 1 : 0, 1);
    end

    // Reset in the middle of WAIT aborts everything.
    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_turn", turn, 0);
    check("rst_wait_num1", num1, 0);
    check("rst_wait_cnt", roll_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
